// File: rtl/lfsr_stream_gen.sv
// Parametrised Galois/Fibonacci LFSR word generator with a valid/ready output,
// multi-step advance, zero-seed replacement and a 1-based period counter.
//
// state    | meaning
// UNSEEDED | after reset; enable ignored until the first load_evt
// RUN      | seeded; words are produced while enable is high
module lfsr_stream_gen #(
  parameter int unsigned          BIT_WIDTH = 8,
  parameter logic [BIT_WIDTH-1:0] POLY      = 8'hB8,
  parameter int unsigned          MODE      = 0,
  parameter int unsigned          STEPS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 load_evt,
  input  logic [BIT_WIDTH-1:0] seed_data,
  input  logic                 lfsr_rdy,
  output logic                 lfsr_vld,
  output logic [BIT_WIDTH-1:0] lfsr_data,
  output logic                 lfsr_done,
  output logic [BIT_WIDTH-1:0] period_cnt,
  output logic                 seed_zero_err
);

  typedef enum logic {UNSEEDED = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [BIT_WIDTH-1:0] state_q, state_d;
  logic [BIT_WIDTH-1:0] seed_q, seed_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 vld_q, vld_d;
  logic                 done_q, done_d;
  logic                 zerr_q, zerr_d;
  logic [BIT_WIDTH-1:0] next_state;
  logic [BIT_WIDTH-1:0] seed_load;
  logic                 advance;

  function automatic logic [BIT_WIDTH-1:0] step1(input logic [BIT_WIDTH-1:0] s);
    if (MODE == 0) step1 = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    else           step1 = {s[BIT_WIDTH-2:0], ^(s & POLY)};
  endfunction

  always_comb begin
    next_state = state_q;
    for (int unsigned i = 0; i < STEPS; i++) next_state = step1(next_state);
  end

  // An all-zero seed would lock the register, so it is swapped for all-ones.
  assign seed_load = (seed_data == '0) ? '1 : seed_data;
  assign advance   = (fsm_q == RUN) && enable && (!vld_q || lfsr_rdy) && !load_evt;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    seed_d  = seed_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    done_d  = done_q;
    zerr_d  = 1'b0;
    if (load_evt) begin
      fsm_d   = RUN;
      state_d = seed_load;
      seed_d  = seed_load;
      cnt_d   = '0;
      vld_d   = 1'b0;
      done_d  = 1'b0;
      zerr_d  = (seed_data == '0);
    end else if (advance) begin
      data_d  = state_q;
      vld_d   = 1'b1;
      state_d = next_state;
      done_d  = (next_state == seed_q);
      cnt_d   = done_q ? BIT_WIDTH'(1) : cnt_q + BIT_WIDTH'(1);
    end else if (lfsr_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= UNSEEDED;
      state_q <= '0;
      seed_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      zerr_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      zerr_q  <= zerr_d;
    end
  end

  assign lfsr_vld      = vld_q;
  assign lfsr_data     = data_q;
  assign lfsr_done     = done_q;
  assign period_cnt    = cnt_q;
  assign seed_zero_err = zerr_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Directed bench for lfsr_stream_gen: Galois/Fibonacci/two-step sequences,
// zero seed, backpressure, load priority, reset and twin-checker pairing.
module tb_lfsr_stream_gen;

  logic       clk = 1'b0;
  logic       rst, en, ld, rdy;
  logic [7:0] seed;
  logic       c_en, c_ld, c_rdy;
  logic [7:0] c_seed;

  logic       g_vld, g_done, g_zerr;
  logic [7:0] g_data, g_cnt;
  logic       s2_vld, s2_done, s2_zerr;
  logic [7:0] s2_data, s2_cnt;
  logic       f_vld, f_done, f_zerr;
  logic [7:0] f_data, f_cnt;
  logic       c_vld, c_done, c_zerr;
  logic [7:0] c_data, c_cnt;

  int vec  = 0;
  int miss = 0;
  int gn, cw;
  logic [7:0] exp_g, exp_s2, exp_f;
  logic [7:0] q[$];
  logic [7:0] gal_hand[6];
  logic [7:0] s2_hand[3];
  logic [7:0] fib_hand[5];

  always #5 clk = ~clk;

  lfsr_stream_gen dut (
    .clk(clk), .rst(rst), .enable(en), .load_evt(ld), .seed_data(seed), .lfsr_rdy(rdy),
    .lfsr_vld(g_vld), .lfsr_data(g_data), .lfsr_done(g_done), .period_cnt(g_cnt),
    .seed_zero_err(g_zerr));

  lfsr_stream_gen #(.STEPS(2)) dut_s2 (
    .clk(clk), .rst(rst), .enable(en), .load_evt(ld), .seed_data(seed), .lfsr_rdy(rdy),
    .lfsr_vld(s2_vld), .lfsr_data(s2_data), .lfsr_done(s2_done), .period_cnt(s2_cnt),
    .seed_zero_err(s2_zerr));

  lfsr_stream_gen #(.MODE(1)) dut_fib (
    .clk(clk), .rst(rst), .enable(en), .load_evt(ld), .seed_data(seed), .lfsr_rdy(rdy),
    .lfsr_vld(f_vld), .lfsr_data(f_data), .lfsr_done(f_done), .period_cnt(f_cnt),
    .seed_zero_err(f_zerr));

  lfsr_stream_gen dut_chk (
    .clk(clk), .rst(rst), .enable(c_en), .load_evt(c_ld), .seed_data(c_seed), .lfsr_rdy(c_rdy),
    .lfsr_vld(c_vld), .lfsr_data(c_data), .lfsr_done(c_done), .period_cnt(c_cnt),
    .seed_zero_err(c_zerr));

  function automatic logic [7:0] gal1(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [7:0] fib1(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] s);
    ld   = 1'b1;
    seed = s;
    tick();
    ld   = 1'b0;
  endtask

  initial begin
    gal_hand = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    s2_hand  = '{8'h01, 8'h5C, 8'h17};
    fib_hand = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    rst = 1'b1; en = 1'b1; ld = 1'b0; seed = 8'h00; rdy = 1'b1;
    c_en = 1'b0; c_ld = 1'b0; c_seed = 8'h00; c_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Unseeded: enable is high but nothing may come out
    repeat (3) tick();
    chk("reset_vld", 32'(g_vld), 32'(0));
    chk("reset_data", 32'(g_data), 32'(0));
    chk("reset_done", 32'(g_done), 32'(0));
    chk("reset_cnt", 32'(g_cnt), 32'(0));
    chk("reset_zerr", 32'(g_zerr), 32'(0));

    // Seed 01 on all three parameterisations, one full period plus wrap
    load(8'h01);
    chk("load_latency_vld", 32'(g_vld), 32'(0));
    exp_g = 8'h01; exp_s2 = 8'h01; exp_f = 8'h01;
    for (int n = 1; n <= 256; n++) begin
      tick();
      chk("gal_vld", 32'(g_vld), 32'(1));
      chk("gal_word", 32'(g_data), 32'(exp_g));
      chk("gal_cnt", 32'(g_cnt), 32'(((n - 1) % 255) + 1));
      chk("gal_done", 32'(g_done), 32'(n == 255));
      chk("s2_word", 32'(s2_data), 32'(exp_s2));
      chk("s2_done", 32'(s2_done), 32'(n == 255));
      chk("fib_word", 32'(f_data), 32'(exp_f));
      chk("fib_done", 32'(f_done), 32'(n == 255));
      if (n <= 6) chk("gal_hand", 32'(g_data), 32'(gal_hand[n-1]));
      if (n <= 3) chk("s2_hand", 32'(s2_data), 32'(s2_hand[n-1]));
      if (n <= 5) chk("fib_hand", 32'(f_data), 32'(fib_hand[n-1]));
      if (n == 256) begin
        chk("gal_wrap_word", 32'(g_data), 32'(8'h01));
        chk("gal_wrap_cnt", 32'(g_cnt), 32'(1));
      end
      exp_g  = gal1(exp_g);
      exp_s2 = gal1(gal1(exp_s2));
      exp_f  = fib1(exp_f);
    end

    // Zero seed loaded while words are streaming: load wins, no word that cycle
    load(8'h00);
    chk("zero_zerr_pulse", 32'(g_zerr), 32'(1));
    chk("prio_load_no_word", 32'(g_vld), 32'(0));
    tick();
    chk("zero_zerr_clear", 32'(g_zerr), 32'(0));
    chk("zero_first_vld", 32'(g_vld), 32'(1));
    chk("zero_first_word", 32'(g_data), 32'(8'hFF));
    chk("zero_first_cnt", 32'(g_cnt), 32'(1));
    exp_g = gal1(8'hFF);
    for (int n = 2; n <= 256; n++) begin
      tick();
      chk("zero_word", 32'(g_data), 32'(exp_g));
      chk("zero_done", 32'(g_done), 32'(n == 255));
      exp_g = gal1(exp_g);
    end

    // Backpressure on word 3
    load(8'h01);
    tick(); tick(); tick();
    chk("bp_word3", 32'(g_data), 32'(8'h5C));
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_vld", 32'(g_vld), 32'(1));
      chk("bp_hold_data", 32'(g_data), 32'(8'h5C));
      chk("bp_hold_cnt", 32'(g_cnt), 32'(3));
    end
    rdy = 1'b1;
    tick();
    chk("bp_next_word", 32'(g_data), 32'(8'h2E));
    chk("bp_next_cnt", 32'(g_cnt), 32'(4));

    // Enable dropped while stalled: word held until accepted, then valid drops
    rdy = 1'b0; en = 1'b0;
    tick();
    chk("en_off_hold_vld", 32'(g_vld), 32'(1));
    chk("en_off_hold_data", 32'(g_data), 32'(8'h2E));
    rdy = 1'b1;
    tick();
    chk("en_off_drain", 32'(g_vld), 32'(0));
    tick();
    chk("en_off_idle", 32'(g_vld), 32'(0));

    // Resume, then reset mid-run
    en = 1'b1;
    tick(); tick();
    chk("resume_word", 32'(g_data), 32'(8'hB3));
    rst = 1'b1;
    tick();
    chk("rst_vld", 32'(g_vld), 32'(0));
    chk("rst_data", 32'(g_data), 32'(0));
    chk("rst_cnt", 32'(g_cnt), 32'(0));
    chk("rst_done", 32'(g_done), 32'(0));
    chk("rst_zerr", 32'(g_zerr), 32'(0));
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_en_ignored", 32'(g_vld), 32'(0));

    // Twin checker reloaded from the generator's 10th word
    load(8'h5A);
    c_en = 1'b1;
    gn = 0; cw = 0;
    for (int it = 0; it < 1300; it++) begin
      tick();
      if (c_vld) begin
        cw++;
        if (q.size() > 0) chk("twin_word", 32'(c_data), 32'(q.pop_front()));
        else chk("twin_underflow", 32'(q.size()), 32'(1));
      end
      c_ld = 1'b0;
      if (g_vld) begin
        gn++;
        if (gn >= 10) q.push_back(g_data);
        if (gn == 10) begin
          c_ld   = 1'b1;
          c_seed = g_data;
        end
      end
    end
    chk("twin_span", 32'(cw >= 1020), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
